uart_tx_dev: RTL and testbench
==============================

Name: uart_tx_dev

Overview:
Memory-mapped UART transmitter that responds to the bridge device interface alongside the two timers: device write enable, word address, write data, combinational read data and an interrupt line into HWInt. The CPU writes bytes into a small FIFO. The block serialises them 8N1 on a TX pin at a programmable baud divisor. It raises IRQ when the FIFO drains after a frame completes.

Parameters:
FIFO_DEPTH, 4, number of byte entries in the TX FIFO (power of two, 2..16)
BAUD_RST, 16, reset value of the BAUD register (clk cycles per bit)

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  synchronous, active-high reset
WE  input  1  device write enable from bridge
Addr  input  32  byte address from bridge; only Addr[3:2] decoded
WD  input  32  write data from bridge
RD  output  32  read data to bridge, combinational on Addr[3:2]
IRQ  output  1  interrupt request, level, routed to a free HWInt bit
tx  output  1  serial output, idle high

Behaviour:
Registers, selected by Addr[3:2]:
- 0 DATA: write pushes WD[7:0] into the FIFO; read returns 0.
- 1 STATUS, read-only bits:
  - bit0 busy: FSM not IDLE
  - bit1 full
  - bit2 empty
  - bit3 irq_pend
  - bit4 overflow
  - bits[31:5] read 0
  - Any write to STATUS clears irq_pend and overflow.
- 2 CTRL: bit0 en, bit1 irq_en; other bits write-ignored and read 0.
- 3 BAUD: bits[15:0] divisor, read back as written, upper bits 0; a value of 0 behaves as 1.

Reset values (applied at the rising edge with reset=1, overriding any concurrent WE):
- tx=1, IRQ=0, FSM IDLE, FIFO empty, CTRL=0, BAUD=BAUD_RST, irq_pend=0, overflow=0.
- Reset mid-frame aborts it; tx is 1 from the next edge.

FIFO:
- Circular buffer with rd/wr pointers and a count.
- Push when full: byte dropped, overflow set (sticky).
- Push and pop in the same cycle: both occur, count unchanged.
- Push to an empty FIFO while the FSM pops in the same cycle cannot happen, because pop requires non-empty.

FSM states: IDLE, START, DATA, STOP.
- Bit counter baud_cnt counts 0..BAUD-1; each state bit lasts exactly BAUD cycles.
- IDLE: tx=1. If en=1 and FIFO non-empty: pop head into shift register and go to START the next cycle.
- START: tx=0 for one bit time, then go to DATA with bit index 0.
- DATA: tx=shift[0], LSB first; shift right at the end of each bit time; after bit 7, go to STOP.
- STOP: tx=1 for one bit time, then go to IDLE. If FIFO non-empty and en=1 at that edge, go straight to START, loading the next byte (back-to-back frames, no idle gap).
- BAUD writes during a frame take effect at the next bit boundary; BAUD is latched into a bit-length register at each boundary.
- Clearing en mid-frame completes the current frame, then holds IDLE.

Interrupts:
- Latency: first start bit begins 2 cycles after the DATA write edge (push edge, then pop edge).
- irq_pend is set at the end of STOP when the FIFO is empty and no new frame starts.
- IRQ = irq_pend & irq_en.
- If a STATUS write coincides with the set event, set wins.

RD is purely combinational from the registers and Addr; there are no read side effects.

Decomposition:
- Shared package holds:
  - register offset constants (DATA=0, STATUS=1, CTRL=2, BAUD=3)
  - STATUS bit index constants
  - FSM state encoding (2-bit)
- One sub-module, tx_fifo: synchronous FIFO with parameter FIFO_DEPTH, 8-bit width, push/pop/full/empty/count. The top holds the register decode, FSM, baud counter and IRQ logic.

Test Plan:
- Reset then read all four registers -> STATUS=0x4, CTRL=0, BAUD=16, tx=1, IRQ=0.
- BAUD=4, CTRL=0x3, write DATA 0xA5 -> tx low for 4 cycles starting 2 cycles after the write, then bits 1,0,1,0,0,1,0,1 each 4 cycles, stop high 4 cycles. IRQ rises the cycle after stop ends, STATUS=0xC. Write STATUS -> IRQ=0, STATUS=0x4.
- en=0, write 5 bytes 0x01..0x05 with depth 4 -> STATUS shows full and overflow (0x12). Set en -> exactly 4 back-to-back frames 0x01..0x04 with no idle gap, then IRQ.
- Write DATA in the same cycle the FSM pops (FIFO count 1, frame ending) -> count stays 1, both bytes transmitted in order.
- Assert reset during DATA bit 3 -> tx=1 next cycle, FIFO empty, BAUD=16. A subsequent write of 0x5A transmits correctly at BAUD=16.
- BAUD=0 with en=1, send 0xFF -> each bit lasts 1 cycle (10-cycle frame). Change BAUD to 8 mid-frame -> the new length applies from the next bit boundary.

Source files
------------

// File: rtl/uart_tx_dev_pkg.sv
// Shared definitions for the memory-mapped UART transmitter: register map,
// STATUS bit positions and the serialiser state encoding.
package uart_tx_dev_pkg;

    localparam logic [1:0] REG_DATA   = 2'd0;
    localparam logic [1:0] REG_STATUS = 2'd1;
    localparam logic [1:0] REG_CTRL   = 2'd2;
    localparam logic [1:0] REG_BAUD   = 2'd3;

    localparam int ST_BUSY     = 0;
    localparam int ST_FULL     = 1;
    localparam int ST_EMPTY    = 2;
    localparam int ST_IRQ_PEND = 3;
    localparam int ST_OVERFLOW = 4;

    localparam int CTRL_EN     = 0;
    localparam int CTRL_IRQ_EN = 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } tx_state_e;

endpackage

// File: rtl/uart_tx_dev_if.sv
// Bridge-side device bus: write strobe, word address, write data,
// combinational read data and the level interrupt towards HWInt.
interface uart_tx_dev_if;

    logic        WE;
    logic [31:0] Addr;
    logic [31:0] WD;
    logic [31:0] RD;
    logic        IRQ;

    modport master (
        output WE,
        output Addr,
        output WD,
        input  RD,
        input  IRQ
    );

    modport slave (
        input  WE,
        input  Addr,
        input  WD,
        output RD,
        output IRQ
    );

endinterface

// File: rtl/uart_tx_dev_tx_fifo.sv
// Byte-wide synchronous circular FIFO; pushes while full are dropped and
// pops while empty are ignored, so the caller may strobe freely.
module tx_fifo #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          push,
    input  logic [7:0]                    din,
    input  logic                          pop,
    output logic [7:0]                    dout,
    output logic                          full,
    output logic                          empty,
    output logic [$clog2(FIFO_DEPTH):0]   count
);

    localparam int             AW      = $clog2(FIFO_DEPTH);
    localparam logic [AW:0]    DEPTH_C = (AW + 1)'(FIFO_DEPTH);

    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == DEPTH_C);
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];

    // Pointers wrap on their own because the depth is a power of two.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

endmodule

// File: rtl/uart_tx_dev.sv
// Memory-mapped 8N1 UART transmitter: register decode, TX FIFO, bit-timing
// serialiser and drain interrupt.
module uart_tx_dev
    import uart_tx_dev_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int BAUD_RST   = 16
) (
    input  logic         clk,
    input  logic         reset,
    uart_tx_dev_if.slave bus,
    output logic         tx
);

    logic [1:0]  sel;
    logic        wr_data;
    logic        wr_status;
    logic        wr_ctrl;
    logic        wr_baud;

    logic        en_q;
    logic        irq_en_q;
    logic        irq_pend_q;
    logic        overflow_q;
    logic [15:0] baud_q;

    tx_state_e   state_q;
    tx_state_e   state_d;
    logic [15:0] baud_cnt_q;
    logic [15:0] bit_len_q;
    logic [2:0]  bit_idx_q;
    logic [7:0]  shift_q;
    logic        bit_end;
    logic        busy;
    logic        pop;
    logic        irq_set;

    logic        fifo_full;
    logic        fifo_empty;
    logic [7:0]  fifo_head;
    logic [$clog2(FIFO_DEPTH):0] fifo_count;

    logic [31:0] rd_data;
    logic        unused_bits;

    // A divisor of zero would stall the bit counter, so it runs as one.
    function automatic logic [15:0] sat_baud(input logic [15:0] b);
        return (b == 16'd0) ? 16'd1 : b;
    endfunction

    assign sel       = bus.Addr[3:2];
    assign wr_data   = bus.WE && (sel == REG_DATA);
    assign wr_status = bus.WE && (sel == REG_STATUS);
    assign wr_ctrl   = bus.WE && (sel == REG_CTRL);
    assign wr_baud   = bus.WE && (sel == REG_BAUD);

    assign unused_bits = ^{bus.Addr[31:4], bus.Addr[1:0], bus.WD[31:16], fifo_count};

    tx_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (wr_data),
        .din   (bus.WD[7:0]),
        .pop   (pop),
        .dout  (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign bit_end = (baud_cnt_q == bit_len_q - 16'd1);
    assign busy    = (state_q != S_IDLE);

    always_comb begin
        state_d = state_q;
        pop     = 1'b0;
        irq_set = 1'b0;
        tx      = 1'b1;
        case (state_q)
            S_IDLE: begin
                if (en_q && !fifo_empty) begin
                    pop     = 1'b1;
                    state_d = S_START;
                end
            end
            S_START: begin
                tx = 1'b0;
                if (bit_end) begin
                    state_d = S_DATA;
                end
            end
            S_DATA: begin
                tx = shift_q[0];
                if (bit_end && (bit_idx_q == 3'd7)) begin
                    state_d = S_STOP;
                end
            end
            S_STOP: begin
                if (bit_end) begin
                    // Chain straight into the next frame when a byte is waiting.
                    if (en_q && !fifo_empty) begin
                        pop     = 1'b1;
                        state_d = S_START;
                    end else begin
                        state_d = S_IDLE;
                        irq_set = fifo_empty;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            baud_cnt_q <= '0;
            bit_len_q  <= sat_baud(16'(BAUD_RST));
            bit_idx_q  <= '0;
        end else begin
            state_q <= state_d;
            if (pop) begin
                baud_cnt_q <= '0;
                bit_len_q  <= sat_baud(baud_q);
                bit_idx_q  <= '0;
            end else if (busy) begin
                if (bit_end) begin
                    baud_cnt_q <= '0;
                    bit_len_q  <= sat_baud(baud_q);
                    if (state_q == S_DATA) begin
                        bit_idx_q <= bit_idx_q + 3'd1;
                    end
                end else begin
                    baud_cnt_q <= baud_cnt_q + 16'd1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (pop) begin
            shift_q <= fifo_head;
        end else if ((state_q == S_DATA) && bit_end) begin
            shift_q <= shift_q >> 1;
        end
    end

    // A drain event in the same cycle as a STATUS write keeps irq_pend set.
    always_ff @(posedge clk) begin
        if (reset) begin
            en_q       <= 1'b0;
            irq_en_q   <= 1'b0;
            baud_q     <= 16'(BAUD_RST);
            irq_pend_q <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            if (wr_ctrl) begin
                en_q     <= bus.WD[CTRL_EN];
                irq_en_q <= bus.WD[CTRL_IRQ_EN];
            end
            if (wr_baud) begin
                baud_q <= bus.WD[15:0];
            end
            if (irq_set) begin
                irq_pend_q <= 1'b1;
            end else if (wr_status) begin
                irq_pend_q <= 1'b0;
            end
            if (wr_data && fifo_full) begin
                overflow_q <= 1'b1;
            end else if (wr_status) begin
                overflow_q <= 1'b0;
            end
        end
    end

    always_comb begin
        rd_data = '0;
        case (sel)
            REG_STATUS: begin
                rd_data[ST_BUSY]     = busy;
                rd_data[ST_FULL]     = fifo_full;
                rd_data[ST_EMPTY]    = fifo_empty;
                rd_data[ST_IRQ_PEND] = irq_pend_q;
                rd_data[ST_OVERFLOW] = overflow_q;
            end
            REG_CTRL: begin
                rd_data[CTRL_EN]     = en_q;
                rd_data[CTRL_IRQ_EN] = irq_en_q;
            end
            REG_BAUD: rd_data[15:0] = baud_q;
            default:  rd_data = '0;
        endcase
    end

    assign bus.RD  = rd_data;
    assign bus.IRQ = irq_pend_q & irq_en_q;

endmodule

// File: tb/tb_uart_tx_dev.sv
// Directed bench for uart_tx_dev: register access, frame timing, FIFO
// overflow, back-to-back frames, mid-frame reset and baud changes.
module tb_uart_tx_dev;
    import uart_tx_dev_pkg::*;

    logic clk;
    logic reset;
    logic tx;
    int   n_pass;
    int   n_chk;

    uart_tx_dev_if bus ();

    uart_tx_dev #(
        .FIFO_DEPTH (4),
        .BAUD_RST   (16)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave),
        .tx    (tx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, got running required finished");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic wr_reg(input logic [1:0] idx, input logic [31:0] d);
        bus.WE   = 1'b1;
        bus.Addr = {28'd0, idx, 2'b00};
        bus.WD   = d;
        @(posedge clk);
        #1;
        bus.WE   = 1'b0;
    endtask

    task automatic rd_reg(input logic [1:0] idx, output logic [31:0] v);
        bus.Addr = {28'd0, idx, 2'b00};
        #1;
        v = bus.RD;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Samples one frame; the first n_a bits last bl_a cycles, the rest bl_b.
    task automatic cap_frame(input int bl_a, input int n_a, input int bl_b,
                             output logic [9:0] bits, output int bad);
        int bl;
        bits = '0;
        bad  = 0;
        for (int k = 0; k < 10; k++) begin
            bl = (k < n_a) ? bl_a : bl_b;
            for (int c = 0; c < bl; c++) begin
                step();
                if (c == 0) bits[k] = tx;
                else if (tx !== bits[k]) bad++;
            end
        end
    endtask

    function automatic logic [31:0] frm(input logic [7:0] b);
        return {22'd0, 1'b1, b, 1'b0};
    endfunction

    initial begin : main
        logic [31:0] v;
        logic [9:0]  f0, f1, f2, f3;
        int          b0, b1, b2, b3;
        n_pass   = 0;
        n_chk    = 0;
        reset    = 1'b1;
        bus.WE   = 1'b0;
        bus.Addr = '0;
        bus.WD   = '0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;

        rd_reg(REG_DATA, v);   chk("rst_data", v, 32'h0);
        rd_reg(REG_STATUS, v); chk("rst_status", v, 32'h4);
        rd_reg(REG_CTRL, v);   chk("rst_ctrl", v, 32'h0);
        rd_reg(REG_BAUD, v);   chk("rst_baud", v, 32'd16);
        chk("rst_tx", tx, 1'b1);
        chk("rst_irq", bus.IRQ, 1'b0);

        // Single frame 0xA5 at 4 cycles per bit
        wr_reg(REG_BAUD, 32'd4);
        wr_reg(REG_CTRL, 32'h3);
        rd_reg(REG_CTRL, v);   chk("ctrl_rb", v, 32'h3);
        wr_reg(REG_DATA, 32'hA5);
        cap_frame(4, 10, 4, f0, b0);
        chk("a5_frame", f0, frm(8'hA5));
        chk("a5_stable", b0, 0);
        chk("a5_irq_in_stop", bus.IRQ, 1'b0);
        step();
        chk("a5_irq", bus.IRQ, 1'b1);
        rd_reg(REG_STATUS, v); chk("a5_status", v, 32'hC);
        wr_reg(REG_STATUS, 32'h0);
        chk("a5_irq_clr", bus.IRQ, 1'b0);
        rd_reg(REG_STATUS, v); chk("a5_status_clr", v, 32'h4);

        // Overflow with transmitter disabled, then drain back-to-back
        wr_reg(REG_CTRL, 32'h2);
        for (int i = 1; i <= 5; i++) wr_reg(REG_DATA, 32'(i));
        rd_reg(REG_STATUS, v); chk("ovf_status", v, 32'h12);
        wr_reg(REG_CTRL, 32'h3);
        cap_frame(4, 10, 4, f0, b0);
        cap_frame(4, 10, 4, f1, b1);
        cap_frame(4, 10, 4, f2, b2);
        cap_frame(4, 10, 4, f3, b3);
        chk("b2b_f1", f0, frm(8'h01));
        chk("b2b_f2", f1, frm(8'h02));
        chk("b2b_f3", f2, frm(8'h03));
        chk("b2b_f4", f3, frm(8'h04));
        chk("b2b_stable", b0 + b1 + b2 + b3, 0);
        chk("b2b_irq_in_stop", bus.IRQ, 1'b0);
        step();
        chk("b2b_irq", bus.IRQ, 1'b1);
        rd_reg(REG_STATUS, v); chk("b2b_status", v, 32'h1C);
        wr_reg(REG_STATUS, 32'h0);

        // Push coinciding with the pop at the end of a frame
        wr_reg(REG_DATA, 32'h11);
        fork
            begin
                cap_frame(4, 10, 4, f0, b0);
                cap_frame(4, 10, 4, f1, b1);
                cap_frame(4, 10, 4, f2, b2);
            end
            begin
                wr_reg(REG_DATA, 32'h22);
                repeat (39) step();
                wr_reg(REG_DATA, 32'h33);
                rd_reg(REG_STATUS, v);
                chk("pp_status", v, 32'h1);
            end
        join
        chk("pp_f1", f0, frm(8'h11));
        chk("pp_f2", f1, frm(8'h22));
        chk("pp_f3", f2, frm(8'h33));
        chk("pp_stable", b0 + b1 + b2, 0);
        step();
        chk("pp_irq", bus.IRQ, 1'b1);
        wr_reg(REG_STATUS, 32'h0);

        // Reset during data bit 3 of 0xC3
        wr_reg(REG_DATA, 32'hC3);
        repeat (18) step();
        chk("rst_mid_bit3", tx, 1'b0);
        reset = 1'b1;
        step();
        chk("rst_mid_tx", tx, 1'b1);
        reset = 1'b0;
        rd_reg(REG_STATUS, v); chk("rst_mid_status", v, 32'h4);
        rd_reg(REG_BAUD, v);   chk("rst_mid_baud", v, 32'd16);
        rd_reg(REG_CTRL, v);   chk("rst_mid_ctrl", v, 32'h0);
        wr_reg(REG_CTRL, 32'h3);
        wr_reg(REG_DATA, 32'h5A);
        cap_frame(16, 10, 16, f0, b0);
        chk("b16_frame", f0, frm(8'h5A));
        chk("b16_stable", b0, 0);
        step();
        chk("b16_irq", bus.IRQ, 1'b1);
        wr_reg(REG_STATUS, 32'h0);

        // Divisor 0 runs as 1 cycle per bit
        wr_reg(REG_BAUD, 32'd0);
        rd_reg(REG_BAUD, v);   chk("b0_rb", v, 32'd0);
        wr_reg(REG_DATA, 32'hFF);
        cap_frame(1, 10, 1, f0, b0);
        chk("b0_frame", f0, frm(8'hFF));
        step();
        chk("b0_irq", bus.IRQ, 1'b1);
        wr_reg(REG_STATUS, 32'h0);

        // Divisor change mid-frame applies from the following bit boundary
        wr_reg(REG_DATA, 32'h35);
        fork
            cap_frame(1, 2, 8, f0, b0);
            begin
                step();
                wr_reg(REG_BAUD, 32'd8);
            end
        join
        chk("bchg_frame", f0, frm(8'h35));
        chk("bchg_stable", b0, 0);
        rd_reg(REG_BAUD, v);   chk("bchg_rb", v, 32'd8);
        step();
        chk("bchg_irq", bus.IRQ, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
